// File: rtl/cfg_mem_pkg.sv
// rtl/cfg_mem_pkg.sv - shared types and helpers for the configuration memory
package cfg_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } frame_state_e;

  typedef struct packed {
    logic ok;
    logic illegal;
  } pair_dec_t;

  function automatic int cnt_width(input int nbits);
    return $clog2(nbits + 1);
  endfunction

  // Complementary strobe pair: (1,0) is a request, (1,1) is illegal, the rest idle.
  function automatic pair_dec_t decode_pair(input logic t, input logic c);
    pair_dec_t r;
    r.ok      = t & ~c;
    r.illegal = t & c;
    return r;
  endfunction

endpackage

// File: rtl/cfg_shift_frame.sv
// rtl/cfg_shift_frame.sv - serial bitstream shadow register, bit counter and load FSM
module cfg_shift_frame
  import cfg_mem_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ser_start,
  input  logic                      ser_in,
  input  logic                      ser_en,
  output logic [WORD_W*DEPTH-1:0]   shadow,
  output logic                      commit,
  output logic                      ser_busy,
  output logic                      ser_done
);

  localparam int N  = WORD_W * DEPTH;
  localparam int CW = cnt_width(N);

  frame_state_e      state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N-1:0]      shadow_q, shadow_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ser_start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (ser_en) begin
          shadow_d = {shadow_q[N-2:0], ser_in};
          cnt_d    = cnt_q + CW'(1);
          // Last bit of the frame: done pulse lines up with the commit cycle.
          if (cnt_q == CW'(N - 1)) begin
            state_d = COMMIT;
            done_d  = 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign shadow   = shadow_q;
  assign commit   = (state_q == COMMIT);
  assign ser_busy = busy_q;
  assign ser_done = done_q;

endmodule

// File: rtl/sram_config_array.sv
// rtl/sram_config_array.sv - DEPTH x WORD_W fabric configuration memory with parallel and serial load
module sram_config_array
  import cfg_mem_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      write,
  input  logic                      writeN,
  input  logic                      read,
  input  logic                      readN,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [WORD_W-1:0]         wdata,
  output logic [WORD_W-1:0]         rdata,
  output logic                      rvalid,
  input  logic                      ser_start,
  input  logic                      ser_in,
  input  logic                      ser_en,
  output logic                      ser_busy,
  output logic                      ser_done,
  output logic                      pair_err,
  output logic [WORD_W*DEPTH-1:0]   prog_bits
);

  logic [WORD_W-1:0]        mem_q [DEPTH];
  logic [WORD_W-1:0]        mem_d [DEPTH];
  logic [WORD_W-1:0]        rdata_q, rdata_d;
  logic                     rvalid_q, rvalid_d;
  logic                     pair_err_q, pair_err_d;
  logic [WORD_W*DEPTH-1:0]  shadow;
  logic                     commit;

  pair_dec_t wdec, rdec;
  logic      illegal, wr_ok, rd_ok, req, in_range, allowed;

  cfg_shift_frame #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_frame (
    .clk       (clk),
    .reset     (reset),
    .ser_start (ser_start),
    .ser_in    (ser_in),
    .ser_en    (ser_en),
    .shadow    (shadow),
    .commit    (commit),
    .ser_busy  (ser_busy),
    .ser_done  (ser_done)
  );

  always_comb begin
    wdec     = decode_pair(write, writeN);
    rdec     = decode_pair(read, readN);
    illegal  = wdec.illegal | rdec.illegal;
    wr_ok    = wdec.ok;
    rd_ok    = rdec.ok & ~wr_ok;
    req      = (wr_ok | rd_ok) & ~illegal;
    in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
    // The parallel port is only live while no serial frame is in flight.
    allowed  = req & ~ser_busy & in_range;

    mem_d = mem_q;
    if (commit) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = shadow[i*WORD_W +: WORD_W];
      end
    end else if (allowed && wr_ok) begin
      mem_d[addr] = wdata;
    end

    rvalid_d   = allowed & rd_ok;
    rdata_d    = rvalid_d ? mem_q[addr] : rdata_q;
    pair_err_d = illegal | (req & ~allowed);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      pair_err_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      pair_err_q <= pair_err_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_prog
    assign prog_bits[g*WORD_W +: WORD_W] = ~mem_q[g];
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign pair_err = pair_err_q;

endmodule

// File: tb/tb_sram_config_array.sv
// tb/tb_sram_config_array.sv - self-checking bench for sram_config_array
module tb_sram_config_array;

  localparam int W = 8;
  localparam int D = 16;
  localparam int N = W * D;

  logic           clk = 1'b0;
  logic           reset;
  logic           write, writeN, read, readN;
  logic [3:0]     addr;
  logic [W-1:0]   wdata;
  logic [W-1:0]   rdata;
  logic           rvalid;
  logic           ser_start, ser_in, ser_en;
  logic           ser_busy, ser_done, pair_err;
  logic [N-1:0]   prog_bits;

  sram_config_array #(.WORD_W(W), .DEPTH(D), .ADDR_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .writeN    (writeN),
    .read      (read),
    .readN     (readN),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .ser_start (ser_start),
    .ser_in    (ser_in),
    .ser_en    (ser_en),
    .ser_busy  (ser_busy),
    .ser_done  (ser_done),
    .pair_err  (pair_err),
    .prog_bits (prog_bits)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] ref_mem [D];
  logic [W-1:0] ref_rdata;

  typedef struct {
    logic       w, wn, r, rn;
    logic [3:0] a;
    logic [7:0] d;
    logic       ev;
    logic [7:0] ed;
    logic       ep;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] model_prog();
    logic [N-1:0] p;
    for (int i = 0; i < D; i++) p[i*W +: W] = ~ref_mem[i];
    return p;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
    ref_rdata = '0;
  endtask

  // Parallel-port rules with the serial engine idle.
  task automatic model_apply(input logic w, input logic wn, input logic r, input logic rn,
                             input logic [3:0] a, input logic [7:0] d,
                             output logic ev, output logic [7:0] ed, output logic ep);
    bit wr, rd, ill;
    wr  = w && !wn;
    rd  = r && !rn && !wr;
    ill = (w && wn) || (r && rn);
    ev = 1'b0;
    ep = 1'b0;
    if (ill) ep = 1'b1;
    else if (wr || rd) begin
      if (int'(a) >= D) ep = 1'b1;
      else if (wr) ref_mem[a] = d;
      else begin
        ev = 1'b1;
        ref_rdata = ref_mem[a];
      end
    end
    ed = ref_rdata;
  endtask

  task automatic drive_idle();
    write = 0; writeN = 1; read = 0; readN = 1;
    addr = '0; wdata = '0;
  endtask

  task automatic serial_load(input logic [N-1:0] frame, input bit toggle, input int inject);
    int b;
    int done_at;
    int pos;
    int exp_at;
    ser_start = 1;
    step();
    ser_start = 0;
    chk("busy_after_start", ser_busy, 1);
    b = 0;
    done_at = -1;
    for (int c = 1; c <= 3 * N && done_at < 0; c++) begin
      if (b < N && (!toggle || (c % 2 == 1))) begin
        ser_en = 1;
        ser_in = frame[N-1-b];
        b++;
      end else begin
        ser_en = 0;
      end
      if (c == inject) begin
        write = 1; writeN = 0; addr = 4'd0; wdata = 8'h77; ser_start = 1;
      end
      step();
      if (c == inject) begin
        chk("blocked_write_perr", pair_err, 1);
        chk("busy_mid_load", ser_busy, 1);
        drive_idle();
        ser_start = 0;
      end
      if (ser_done) done_at = c + 1;
    end
    ser_en = 0;
    exp_at = toggle ? 2 * N : N + 1;
    chk("done_latency", done_at, exp_at);
    // First bit shifted lands at the top of the frame.
    for (int k = 0; k < N; k++) begin
      pos = N - 1 - k;
      ref_mem[pos / W][pos % W] = frame[N-1-k];
    end
    step();
    chk("done_single_pulse", ser_done, 0);
    chk("busy_cleared", ser_busy, 0);
    chk("prog_after_load", prog_bits, model_prog());
  endtask

  initial begin
    logic ev, ep;
    logic [7:0] ed;
    logic [N-1:0] frame;
    logic [N-1:0] all_ones;

    tbl[0]  = '{1, 0, 0, 1, 4'd3, 8'hA5, 0, 8'h00, 0};
    tbl[1]  = '{0, 1, 1, 0, 4'd3, 8'h00, 1, 8'hA5, 0};
    tbl[2]  = '{0, 1, 0, 1, 4'd3, 8'h00, 0, 8'hA5, 0};
    tbl[3]  = '{1, 0, 1, 0, 4'd5, 8'h3C, 0, 8'hA5, 0};
    tbl[4]  = '{0, 1, 1, 0, 4'd5, 8'h00, 1, 8'h3C, 0};
    tbl[5]  = '{1, 1, 0, 1, 4'd5, 8'h00, 0, 8'h3C, 1};
    tbl[6]  = '{0, 1, 1, 0, 4'd5, 8'h00, 1, 8'h3C, 0};
    tbl[7]  = '{0, 1, 1, 1, 4'd3, 8'h00, 0, 8'h3C, 1};
    tbl[8]  = '{0, 1, 0, 0, 4'd7, 8'hFF, 0, 8'h3C, 0};
    tbl[9]  = '{1, 0, 1, 1, 4'd0, 8'hFF, 0, 8'h3C, 1};
    tbl[10] = '{0, 0, 1, 0, 4'd0, 8'h00, 1, 8'h00, 0};

    all_ones = '1;
    reset = 1;
    drive_idle();
    ser_start = 0; ser_in = 0; ser_en = 0;
    step();
    step();
    reset = 0;
    model_clear();

    chk("reset_prog_bits", prog_bits, all_ones);
    chk("reset_rdata", rdata, 0);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_ser_busy", ser_busy, 0);
    chk("reset_ser_done", ser_done, 0);
    chk("reset_pair_err", pair_err, 0);

    for (int i = 0; i < 11; i++) begin
      write = tbl[i].w; writeN = tbl[i].wn; read = tbl[i].r; readN = tbl[i].rn;
      addr = tbl[i].a; wdata = tbl[i].d;
      model_apply(tbl[i].w, tbl[i].wn, tbl[i].r, tbl[i].rn, tbl[i].a, tbl[i].d, ev, ed, ep);
      step();
      chk($sformatf("tbl%0d_rvalid", i), rvalid, tbl[i].ev);
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].ed);
      chk($sformatf("tbl%0d_pair_err", i), pair_err, tbl[i].ep);
      chk($sformatf("tbl%0d_prog", i), prog_bits, model_prog());
      if (i == 0) chk("prog_word3_inverted", prog_bits[31:24], 8'h5A);
    end
    drive_idle();

    for (int i = 0; i < 200; i++) begin
      write  = 1'($urandom_range(0, 1));
      writeN = 1'($urandom_range(0, 3) == 0);
      read   = 1'($urandom_range(0, 1));
      readN  = 1'($urandom_range(0, 3) == 0);
      addr   = 4'($urandom_range(0, D - 1));
      wdata  = 8'($urandom);
      model_apply(write, writeN, read, readN, addr, wdata, ev, ed, ep);
      step();
      chk("rand_rvalid", rvalid, ev);
      chk("rand_rdata", rdata, ed);
      chk("rand_pair_err", pair_err, ep);
      chk("rand_prog", prog_bits, model_prog());
    end
    drive_idle();
    step();

    frame = {8{16'hFF00}};
    serial_load(frame, 0, -1);
    chk("ff00_word15", ref_mem[15], 8'hFF);
    read = 1; readN = 0; addr = 4'd14;
    step();
    drive_idle();
    chk("ser_readback_rvalid", rvalid, 1);
    chk("ser_readback_word14", rdata, 8'h00);

    frame = {$urandom, $urandom, $urandom, $urandom};
    serial_load(frame, 1, 50);

    ser_start = 1;
    step();
    ser_start = 0;
    ser_en = 1;
    for (int c = 0; c < 40; c++) begin
      ser_in = 1'($urandom_range(0, 1));
      step();
    end
    ser_en = 0;
    reset = 1;
    step();
    reset = 0;
    model_clear();
    chk("midreset_busy", ser_busy, 0);
    chk("midreset_done", ser_done, 0);
    chk("midreset_prog", prog_bits, all_ones);
    step();
    chk("midreset_stays_idle", ser_busy, 0);

    frame = {$urandom, $urandom, $urandom, $urandom};
    serial_load(frame, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_config_array.md
Name: sram_config_array

Overview:
- Parametrised successor to the single-bit behavioural SRAM configuration cell: a DEPTH x WORD_W configuration memory for fabric programming.
- Supports addressed parallel word write/read and a serial bitstream-load mode.
- Sits between the configuration controller and the fabric routing/LUT cells.
- All stored bits drive the fabric continuously through the inverted prog_bits bus, matching layout polarity.

Parameters:
- WORD_W, 8: bits per configuration word.
- DEPTH, 16: number of words; must be ≥2.
- ADDR_W, 4: address width; must satisfy 2^ADDR_W ≥ DEPTH.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- write  input  1  write strobe, true half of the complementary pair
- writeN  input  1  write strobe, complement half
- read  input  1  read strobe, true half
- readN  input  1  read strobe, complement half
- addr  input  ADDR_W  word address for parallel read/write
- wdata  input  WORD_W  parallel write data
- rdata  output  WORD_W  registered read data
- rvalid  output  1  rdata valid, single-cycle pulse
- ser_start  input  1  begins a serial bitstream load
- ser_in  input  1  serial data bit, sampled when ser_en=1
- ser_en  input  1  shift enable
- ser_busy  output  1  serial load in progress
- ser_done  output  1  one-cycle pulse when the serial frame is committed
- pair_err  output  1  one-cycle pulse on an illegal strobe pair or a blocked request
- prog_bits  output  WORD_W*DEPTH  inverted stored bits; word i occupies [i*WORD_W +: WORD_W]

Behaviour:
- Reset:
  - Array, shadow register, bit counter, rdata, rvalid, ser_busy, ser_done and pair_err all clear to 0.
  - prog_bits therefore resets to all 1s.
  - The FSM returns to IDLE, including when reset is asserted mid-SHIFT; any partial frame is discarded.
- Strobe decode:
  - wr_ok = write & ~writeN.
  - rd_ok = read & ~readN & ~wr_ok.
  - Pair (write, writeN) = (1,1) or (read, readN) = (1,1) is illegal: no array action, pair_err=1 next cycle.
  - Pairs (0,0) and (0,1) mean idle.
- Parallel write:
  - Applies only in IDLE with addr < DEPTH.
  - mem[addr] <= wdata at the clk edge; prog_bits reflects the new value in the same cycle as the register update.
- Parallel read:
  - Applies in IDLE with addr < DEPTH.
  - rdata <= mem[addr] and rvalid=1 on the next cycle.
  - Otherwise rvalid=0 and rdata holds its last value. No tristate.
- Write/read collision: the write wins, no read occurs, and rvalid=0. This preserves single-cell semantics.
- Out-of-range addr (addr ≥ DEPTH): request ignored, pair_err pulse.
- Serial FSM, states IDLE, SHIFT, COMMIT:
  - IDLE -> SHIFT on ser_start=1. Bit counter clears to 0; ser_busy=1 from the next cycle.
  - SHIFT: each cycle with ser_en=1, shadow <= {shadow[N-2:0], ser_in}, where N = WORD_W*DEPTH, and the counter increments. The first bit shifted ends up as MSB of word DEPTH-1.
  - When the counter reaches N-1 with ser_en=1, go to COMMIT.
  - ser_en=0 stalls with no change.
  - COMMIT: array <= shadow as one atomic update; ser_done=1 for one cycle; -> IDLE; ser_busy=0 next cycle.
  - Parallel write/read requests during SHIFT or COMMIT: ignored, pair_err pulse.
  - ser_start during SHIFT: ignored.
- Counter width: $clog2(WORD_W*DEPTH + 1).
- Latency of a full serial load with ser_en held high: ser_done asserts N+1 cycles after the ser_start cycle.

Decomposition:
- Package cfg_mem_pkg holds:
  - FSM state enum (IDLE, SHIFT, COMMIT)
  - a function for the counter width
  - a strobe-pair decode function returning {ok, illegal}
- Natural sub-module: cfg_shift_frame, containing the shadow shift register, bit counter and FSM.
- Top-level sram_config_array contains the array, the parallel port and prog_bits inversion.

Test Plan:
1. Reset, then observe -> prog_bits all 1s, rdata=0, rvalid=0, ser_busy=0.
2. Write addr=3, wdata=0xA5; next cycle read addr=3 -> rdata=0xA5 with rvalid=1 one cycle after the read; prog_bits[31:24]=0x5A.
3. Same cycle write=1/writeN=0 and read=1/readN=0 at addr=5, wdata=0x3C -> mem[5]=0x3C, rvalid=0. Illegal pair write=1/writeN=1 -> no update, pair_err=1.
4. ser_start, then 128 bits with ser_en=1 (pattern 0xFF00 repeated, MSB first) -> ser_done at cycle 129; every word 0xFF or 0x00 per frame order; prog_bits inverted accordingly.
5. Serial load with ser_en toggling every other cycle -> ser_done after 256 enabled/disabled cycles total. A parallel write mid-load is ignored and pulses pair_err.
6. Reset asserted after 40 shifted bits -> FSM IDLE, ser_busy=0, array all 0. A subsequent full load completes normally.
